cki_stream_gen: RTL

- Arithmetic generator for the SM4 key-schedule constant stream CK0..CK31.
- Byte j of CKi = (4i+j)*7 mod 256. The block computes this with running byte accumulators, not a lookup.
- Words go out one per handshake over a valid/ready interface, tagged with the round index, to the key-expansion datapath.
- Replaces the per-round table lookup wherever the consumer needs back-pressure and a start/done sequence.

---
 rtl/cki_stream_gen.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/cki_stream_gen.sv
// ----------------------------------------------------------------------------
// cki_stream_gen
//
// Generates the SM4 key-schedule constant stream CK0..CK(NUM_ROUNDS-1).
// Byte j of CKi is (4i+j)*7 mod 256. Rather than a table, four running byte
// accumulators are advanced by 28 (4*7) per word. Each word is presented on a
// valid/ready handshake and tagged with its round index. A one-cycle done
// pulse follows the transfer of the final word.
//
// Optional feature (macro CKI_REVERSE_EN):
//   Adds input dir_in, sampled together with start_in. dir_in=1 walks the
//   stream downwards from round NUM_ROUNDS-1 to round 0. Without the macro
//   the stream is always ascending.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   start_in   in   1   request a new sequence (only honoured in IDLE)
//   ready_in   in   1   consumer accepts the current word
//   dir_in     in   1   0 = ascending, 1 = descending (CKI_REVERSE_EN only)
//   valid_out  out  1   cki_out/round_out hold a valid word
//   round_out  out  5   round index of the current word
//   cki_out    out  32  CK word {b0,b1,b2,b3}, b0 in [31:24]
//   busy_out   out  1   high while a sequence is running
//   done_out   out  1   one-cycle pulse after the final word transfers
// ----------------------------------------------------------------------------
module cki_stream_gen #(
    parameter int NUM_ROUNDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_in,
    input  logic        ready_in,
`ifdef CKI_REVERSE_EN
    input  logic        dir_in,
`endif
    output logic        valid_out,
    output logic [4:0]  round_out,
    output logic [31:0] cki_out,
    output logic        busy_out,
    output logic        done_out
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [4:0]  LAST_ROUND = 5'(NUM_ROUNDS - 1);
    localparam logic [7:0]  LANE_STEP  = 8'd28;
    localparam logic [31:0] CK_FIRST   = 32'h00070e15;

    // Per-lane offset of the last word relative to CK0: (NUM_ROUNDS-1)*28.
    localparam logic [7:0]  END_OFS    = 8'(((NUM_ROUNDS - 1) * 28) % 256);
    localparam logic [31:0] CK_LAST    = {END_OFS,
                                          END_OFS + 8'h07,
                                          END_OFS + 8'h0e,
                                          END_OFS + 8'h15};

    state_t      state, state_next;
    logic        dir_q, dir_next;
    logic        valid_next, busy_next, done_next;
    logic [4:0]  round_next;
    logic [31:0] cki_next;
    logic        start_dir;
    logic        last_word;

`ifdef CKI_REVERSE_EN
    assign start_dir = dir_in;
`else
    assign start_dir = 1'b0;
`endif

    // Each byte lane moves by 28 on its own; carries never cross lanes.
    function automatic logic [31:0] step_lanes(input logic [31:0] w, input logic down);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            r[j*8 +: 8] = down ? (w[j*8 +: 8] - LANE_STEP) : (w[j*8 +: 8] + LANE_STEP);
        end
        return r;
    endfunction

    // The final word is round 0 when descending, NUM_ROUNDS-1 otherwise.
    assign last_word = dir_q ? (round_out == 5'd0) : (round_out == LAST_ROUND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dir_q     <= 1'b0;
            valid_out <= 1'b0;
            round_out <= 5'd0;
            cki_out   <= 32'd0;
            busy_out  <= 1'b0;
            done_out  <= 1'b0;
        end else begin
            state     <= state_next;
            dir_q     <= dir_next;
            valid_out <= valid_next;
            round_out <= round_next;
            cki_out   <= cki_next;
            busy_out  <= busy_next;
            done_out  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        dir_next   = dir_q;
        valid_next = valid_out;
        round_next = round_out;
        cki_next   = cki_out;
        busy_next  = busy_out;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                // Also reached in the done cycle, so a start there is honoured.
                if (start_in) begin
                    state_next = RUN;
                    dir_next   = start_dir;
                    valid_next = 1'b1;
                    busy_next  = 1'b1;
                    round_next = start_dir ? LAST_ROUND : 5'd0;
                    cki_next   = start_dir ? CK_LAST : CK_FIRST;
                end
            end
            RUN: begin
                if (valid_out && ready_in) begin
                    if (last_word) begin
                        // round_out/cki_out keep the last word after completion.
                        state_next = IDLE;
                        valid_next = 1'b0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        round_next = dir_q ? (round_out - 5'd1) : (round_out + 5'd1);
                        cki_next   = step_lanes(cki_out, dir_q);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
